// File: rtl/seq_mult32.sv
//-----------------------------------------------------------------------------
// seq_mult32 -- iterative shift-and-add unsigned multiplier.
//
// Accepts a WIDTH-bit multiplicand/multiplier pair over a valid/ready
// handshake. It runs WIDTH add/shift iterations and then presents the
// 2*WIDTH-bit product over a second valid/ready handshake.
//
// Optional build macro:
//   SEQ_MULT_ZERO_SKIP_EN - when defined, a zero operand bypasses CALC and
//                           the block goes straight to DONE with product 0.
//
// FSM states
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high, product holds last value
//   CALC  | one add/shift iteration per cycle, cnt counts down to 0
//   DONE  | out_valid high, product held until out_ready
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_mult32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6      // 2**CNT_W must exceed WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 c_q, c_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Partial-product addition: accumulator plus multiplicand when the current
    // multiplier bit is set. C is cleared after every shift, so it enters the
    // adder as a zero carry-in and the true carry-out lives in sum[WIDTH].
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;

    // Adder feeding the shift stage
    always_comb begin
        addend = q_q[0] ? {1'b0, m_q} : '0;
        sum    = {1'b0, a_q} + addend + {{WIDTH{1'b0}}, c_q};
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    q_d     = b;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = CALC;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d   = DONE;
                        product_d = '0;
                    end
`endif
                end
            end

            CALC: begin
                // {C,A,Q} >> 1 with {C,A} = sum: carry lands in A's MSB,
                // the adder's LSB moves into Q's MSB, and C is cleared.
                a_d = sum[WIDTH:1];
                q_d = {sum[0], q_q[WIDTH-1:1]};
                c_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    product_d = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult32.sv
//-----------------------------------------------------------------------------
// tb_seq_mult32 -- self-checking bench for seq_mult32.
// A cycle-count reference model tracks when the block should be idle,
// computing or presenting a result, and what the product must be; a compare
// process checks every cycle against it. Directed cases pin literal values.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_mult32;

    localparam int WIDTH = 32;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    int n_checks = 0;
    int n_err    = 0;

    seq_mult32 #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = computing, 2 = result presented.
    int            m_ph   = 0;
    int            m_left = 0;
    logic [63:0]   m_exp  = '0;
    logic [63:0]   m_prod = '0;

    function automatic bit zero_skip(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MULT_ZERO_SKIP_EN
        return (x == 0) || (y == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
        return zero_skip(x, y) ? 0 : WIDTH;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   = 0;
            m_left = 0;
            m_prod = '0;
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_exp = {32'b0, a} * {32'b0, b};
                    if (zero_skip(a, b)) begin
                        m_ph   = 2;
                        m_prod = '0;
                    end else begin
                        m_ph   = 1;
                        m_left = WIDTH;
                    end
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_ph   = 2;
                        m_prod = m_exp;
                    end
                end
                default: if (out_ready) m_ph = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_in_ready",  64'(in_ready),  64'(m_ph == 0));
            chk("cmp_out_valid", 64'(out_valid), 64'(m_ph == 2));
            chk("cmp_busy",      64'(busy),      64'(m_ph != 0));
            chk("cmp_product",   product,        m_prod);
        end
    end

    // One transaction starting from IDLE; hold = cycles to keep out_ready low in DONE
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input int hold, input bit use_lit, input logic [63:0] lit);
        int          n;
        logic [63:0] want;
        logic [63:0] seen;
        want = use_lit ? lit : ({32'b0, op_a} * {32'b0, op_b});
        @(negedge clk);
        a         = op_a;
        b         = op_b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency_edges", 64'(n), 64'(exp_lat(op_a, op_b)));
        chk("product", product, want);
        seen = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_product", product, seen);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("exit_out_valid", 64'(out_valid), 64'd0);
        chk("exit_in_ready", 64'(in_ready), 64'd1);
        chk("exit_product_held", product, seen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] ra, rb;
        int          sel;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_product",   product,        64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-computed products
        run_op(32'd3, 32'd5, 0, 1'b1, 64'h000000000000000F);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 64'hFFFFFFFE00000001);
        run_op(32'h12345678, 32'h9ABCDEF0, 10, 1'b1, 64'h0B00EA4E242D2080);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        a = 32'd7; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_product",   product,        64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd2, 32'd4, 0, 1'b1, 64'd8);

        // Zero operand
        run_op(32'd0, 32'hDEADBEEF, 0, 1'b1, 64'd0);
        run_op(32'hDEADBEEF, 32'd0, 2, 1'b1, 64'd0);

        // Back-to-back with in_valid held high
        @(negedge clk);
        a = 32'd2; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        a = 32'd4; b = 32'd5;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_latency", 64'(n), 64'(WIDTH));
        chk("b2b_first_product", product, 64'd6);
        @(posedge clk); #1;
        chk("b2b_gap_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_second_accepted", 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_latency", 64'(n), 64'(WIDTH));
        chk("b2b_second_product", product, 64'd20);
        @(posedge clk); #1;

        // Randomized operands and backpressure
        for (int k = 0; k < 14; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 6);
            if (sel == 0) ra = '0;
            if (sel == 1) rb = '0;
            if (sel == 2) begin ra = '1; rb = rb | 32'h8000_0001; end
            run_op(ra, rb, $urandom_range(0, 4), 1'b0, 64'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
